// File: rtl/pool_relu.sv
// pool_relu: 2x2/stride-2 max-pool of the conv output map over an ICB master.
// Define POOL_RELU_EN to clamp negative pooled bytes to zero.
module pool_relu #(
    parameter logic [31:0] IN_BASE  = 32'h6000_0000,
    parameter logic [31:0] OUT_BASE = 32'h6000_4000,
    parameter int unsigned CHN      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        pool_icb_cmd_valid,
    input  logic        pool_icb_cmd_ready,
    output logic [31:0] pool_icb_cmd_addr,
    output logic        pool_icb_cmd_read,
    output logic [31:0] pool_icb_cmd_wdata,
    output logic [3:0]  pool_icb_cmd_wmask,
    input  logic        pool_icb_rsp_valid,
    output logic        pool_icb_rsp_ready,
    input  logic [31:0] pool_icb_rsp_rdata
);
    typedef enum logic [2:0] {
        IDLE, RDA_CMD, RDA_RSP, RDB_CMD, RDB_RSP, WR_CMD, WR_RSP
    } state_t;

    localparam logic [3:0] LAST_C = 4'(CHN - 1);

    state_t      state_q, state_d;
    logic        start_q, start_edge;
    logic [3:0]  c_q, c_d;
    logic [3:0]  r_q, r_d;
    logic [2:0]  w_q, w_d;
    logic [15:0] lo_q, lo_d;
    logic        done_d, valid_d, read_d, buf_we;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  wmask_d;
    logic [31:0] rowbuf_q [8];

    function automatic logic [7:0] smax(input logic [7:0] a,
                                        input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [7:0] pool4(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] c,
                                         input logic [7:0] d);
        logic [7:0] m;
        m = smax(smax(a, b), smax(c, d));
`ifdef POOL_RELU_EN
        if (m[7]) m = 8'h00;
`endif
        return m;
    endfunction

    // top word t and bottom word b cover the same 4 columns -> 2 outputs
    function automatic logic [15:0] pool_word(input logic [31:0] t,
                                              input logic [31:0] b);
        return {pool4(t[31:24], t[23:16], b[31:24], b[23:16]),
                pool4(t[15:8],  t[7:0],   b[15:8],  b[7:0])};
    endfunction

    function automatic logic [31:0] rd_addr(input logic [3:0] c,
                                            input logic [4:0] row,
                                            input logic [2:0] w);
        return IN_BASE + {18'd0, c, row, w, 2'b00};
    endfunction

    function automatic logic [31:0] wr_addr(input logic [3:0] c,
                                            input logic [3:0] r,
                                            input logic [1:0] k);
        return OUT_BASE + {20'd0, c, r, k, 2'b00};
    endfunction

    assign start_edge = start & ~start_q;
    assign pool_icb_rsp_ready = 1'b1;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        w_d     = w_q;
        lo_d    = lo_q;
        done_d  = done;
        valid_d = pool_icb_cmd_valid;
        addr_d  = pool_icb_cmd_addr;
        read_d  = pool_icb_cmd_read;
        wdata_d = pool_icb_cmd_wdata;
        wmask_d = pool_icb_cmd_wmask;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    done_d  = 1'b0;
                    c_d     = 4'd0;
                    r_d     = 4'd0;
                    w_d     = 3'd0;
                    valid_d = 1'b1;
                    read_d  = 1'b1;
                    wmask_d = 4'h0;
                    addr_d  = rd_addr(4'd0, 5'd0, 3'd0);
                    state_d = RDA_CMD;
                end
            end
            RDA_CMD, RDB_CMD, WR_CMD: begin
                if (pool_icb_cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = state_t'(state_q + 3'd1);
                end
            end
            RDA_RSP: begin
                if (pool_icb_rsp_valid) begin
                    buf_we  = 1'b1;
                    valid_d = 1'b1;
                    w_d     = w_q + 3'd1;
                    if (w_q == 3'd7) begin
                        addr_d  = rd_addr(c_q, {r_q, 1'b1}, 3'd0);
                        state_d = RDB_CMD;
                    end else begin
                        addr_d  = rd_addr(c_q, {r_q, 1'b0}, w_q + 3'd1);
                        state_d = RDA_CMD;
                    end
                end
            end
            RDB_RSP: begin
                if (pool_icb_rsp_valid) begin
                    valid_d = 1'b1;
                    if (!w_q[0]) begin
                        lo_d    = pool_word(rowbuf_q[w_q], pool_icb_rsp_rdata);
                        w_d     = w_q + 3'd1;
                        addr_d  = rd_addr(c_q, {r_q, 1'b1}, w_q + 3'd1);
                        state_d = RDB_CMD;
                    end else begin
                        wdata_d = {pool_word(rowbuf_q[w_q], pool_icb_rsp_rdata),
                                   lo_q};
                        read_d  = 1'b0;
                        wmask_d = 4'hF;
                        addr_d  = wr_addr(c_q, r_q, w_q[2:1]);
                        state_d = WR_CMD;
                    end
                end
            end
            WR_RSP: begin
                if (pool_icb_rsp_valid) begin
                    read_d  = 1'b1;
                    wmask_d = 4'h0;
                    valid_d = 1'b1;
                    w_d     = w_q + 3'd1;
                    if (w_q != 3'd7) begin
                        addr_d  = rd_addr(c_q, {r_q, 1'b1}, w_q + 3'd1);
                        state_d = RDB_CMD;
                    end else if (r_q == 4'd15 && c_q == LAST_C) begin
                        c_d     = 4'd0;
                        r_d     = 4'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        r_d     = r_q + 4'd1;
                        if (r_q == 4'd15) c_d = c_q + 4'd1;
                        addr_d  = rd_addr(c_d, {r_d, 1'b0}, 3'd0);
                        state_d = RDA_CMD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            start_q            <= 1'b0;
            c_q                <= 4'd0;
            r_q                <= 4'd0;
            w_q                <= 3'd0;
            lo_q               <= 16'd0;
            done               <= 1'b0;
            pool_icb_cmd_valid <= 1'b0;
            pool_icb_cmd_addr  <= 32'd0;
            pool_icb_cmd_read  <= 1'b0;
            pool_icb_cmd_wdata <= 32'd0;
            pool_icb_cmd_wmask <= 4'h0;
        end else begin
            state_q            <= state_d;
            start_q            <= start;
            c_q                <= c_d;
            r_q                <= r_d;
            w_q                <= w_d;
            lo_q               <= lo_d;
            done               <= done_d;
            pool_icb_cmd_valid <= valid_d;
            pool_icb_cmd_addr  <= addr_d;
            pool_icb_cmd_read  <= read_d;
            pool_icb_cmd_wdata <= wdata_d;
            pool_icb_cmd_wmask <= wmask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) rowbuf_q[w_q] <= pool_icb_rsp_rdata;
    end

endmodule
